mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU, plus the new MADD/MADDU/MSUB/MSUBU accumulate modes.
- Sits in the E stage and is driven by the decoder's start, HI/LO write and HI/LO read controls.
- Exposes a busy flag for the D-stage stall logic; result latency is configurable per operation class.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch an operation this cycle.
- md_op  in  3  operation select (codes in shared header).
- src_a  in  WIDTH  rs operand.
- src_b  in  WIDTH  rt operand.
- hi_write  in  1  mthi.
- lo_write  in  1  mtlo.
- wdata  in  WIDTH  data for mthi/mtlo.
- hi_sel  in  1  1 = rdata shows HI, 0 = LO.
- rdata  out  WIDTH  mfhi/mflo read data, combinational from the HI/LO registers.
- busy  out  1  operation in flight (registered).
- div_zero  out  1  one-cycle pulse when a division with src_b==0 completes.

Behaviour:
- Reset (sync, active-high):
  - HI, LO, counter, latched operands and latched op all clear to 0.
  - busy=0, div_zero=0.
  - Reset mid-operation aborts it and no HI/LO update occurs.
- Start acceptance:
  - start is accepted only when busy=0.
  - Operands and op are latched at the edge ending cycle T.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES).
- Timing:
  - busy=1 during cycles T+1..T+N.
  - HI/LO are written at the edge ending cycle T+N; busy=0 and the new HI/LO are visible in cycle T+N+1.
  - Back-to-back: a start in cycle T+N+1 is accepted.
- start while busy=1: ignored; HI/LO and the counter are unaffected. The stall logic must prevent this, and a bench assertion flags it.
- mthi/mtlo:
  - Written at the clock edge when busy=0 and start=0.
  - Ignored while busy=1.
  - If start and hi_write/lo_write occur in the same cycle, start wins and the write is dropped.
  - hi_write and lo_write together write both registers with wdata.
- Operation results:
  - mult: signed 2*WIDTH product. {HI,LO} = product.
  - multu: unsigned 2*WIDTH product. {HI,LO} = product.
  - madd/maddu: {HI,LO} = {HI,LO} + product, using the HI/LO value at completion time, modulo 2^(2*WIDTH).
  - msub/msubu: {HI,LO} = {HI,LO} - product, same rules.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div overflow case: MIN_INT / -1 gives LO = MIN_INT, HI = 0.
  - divu: unsigned quotient and remainder.
- Divide by zero (div or divu with src_b==0):
  - HI/LO unchanged.
  - busy still lasts DIV_CYCLES.
  - div_zero pulses high in cycle T+N+1.
- rdata: purely combinational mux of the HI/LO register outputs. No bypass of the in-flight result; mfhi/mflo must stall while busy.
- Undefined md_op codes: accepted and time out as MULT_CYCLES with no HI/LO change.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES)+1) bits. Countdown reaching 1 is the completion cycle.

Decomposition:
- Shared constants header (same style as the existing ALU-op header) holds the md_op codes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- The decoder is extended to emit md_op alongside Start.
- One sub-module, mdu_result_calc: purely combinational.
  - Inputs: latched op, operands, current HI/LO.
  - Outputs: next HI/LO and a div-by-zero flag.
- mdu_unit keeps the counter, busy, latching, mthi/mtlo arbitration and the HI/LO registers.

Test Plan:
- mult: src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu 7/0 after mthi/mtlo 0x11/0x22 -> HI/LO unchanged; div_zero pulses 1 cycle at T+11.
- div: src_a=-7, src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- maddu with HI=0, LO=0xFFFFFFFF, operands 1,1 -> HI=1, LO=0.
- msub with HI=LO=0, operands 1,1 -> HI=LO=0xFFFFFFFF.
- Arbitration:
  - mtlo during busy -> LO unchanged.
  - start together with mthi -> the mthi write is dropped.
  - reset at cycle T+3 of a mult -> busy=0, HI=LO=0 next cycle, and no later update.
  - start asserted at T+N+1 -> the new operation is accepted.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared md_op codes and operation-class helpers for the multiply/divide unit.
// Even codes are the signed variants, odd codes the unsigned ones.
package mdu_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;
    localparam logic [2:0] MD_MSUB  = 3'd6;
    localparam logic [2:0] MD_MSUBU = 3'd7;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// Combinational HI/LO next-value calculation for a latched md_op and operands.
// Zero latency; no flow control, the parent decides when the result is committed.
module mdu_result_calc
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    logic                   sgn;
    logic [2*WIDTH-1:0]     a_ext;
    logic [2*WIDTH-1:0]     b_ext;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     acc;
    logic                   a_neg;
    logic                   b_neg;
    logic                   b_zero;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH-1:0]       b_safe;
    logic [WIDTH-1:0]       q_mag;
    logic [WIDTH-1:0]       r_mag;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       rem;

    assign sgn   = md_is_signed(op_i);
    // Extending to 2*WIDTH makes the truncated product correct for both signednesses.
    assign a_ext = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
    assign b_ext = {{WIDTH{sgn & b_i[WIDTH-1]}}, b_i};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_i, lo_i};

    assign a_neg  = sgn & a_i[WIDTH-1];
    assign b_neg  = sgn & b_i[WIDTH-1];
    assign b_zero = (b_i == '0);
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;
    // MIN_INT / -1 falls out naturally: |a| = 2^(W-1) reads back as MIN_INT.
    assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        hi_o       = hi_i;
        lo_o       = lo_i;
        div_zero_o = 1'b0;
        case (op_i)
            MD_MULT, MD_MULTU: {hi_o, lo_o} = prod;
            MD_MADD, MD_MADDU: {hi_o, lo_o} = acc + prod;
            MD_MSUB, MD_MSUBU: {hi_o, lo_o} = acc - prod;
            MD_DIV, MD_DIVU: begin
                if (b_zero) begin
                    div_zero_o = 1'b1;
                end else begin
                    hi_o = rem;
                    lo_o = quo;
                end
            end
            default: begin
                hi_o = hi_i;
                lo_o = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding architectural HI/LO; result after MULT_CYCLES/DIV_CYCLES.
// Busy is registered and the decoder must stall start and mfhi/mflo while it is high.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_sel,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             div_zero
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic             calc_dz;

    mdu_result_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .hi_o       (calc_hi),
        .lo_o       (calc_lo),
        .div_zero_o (calc_dz)
    );

    // Priority: in-flight op, then start, then mthi/mtlo; a start while busy is dropped.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dz_d   = 1'b0;
        if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                hi_d   = calc_hi;
                lo_d   = calc_lo;
                dz_d   = calc_dz;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (start) begin
            op_d   = md_op;
            a_d    = src_a;
            b_d    = src_b;
            busy_d = 1'b1;
            cnt_d  = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
        end else begin
            if (hi_write) hi_d = wdata;
            if (lo_write) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dz_q   <= dz_d;
        end
    end

    assign rdata    = hi_sel ? hi_q : lo_q;
    assign busy     = busy_q;
    assign div_zero = dz_q;

endmodule
